idex_stage: RTL

Registered ID/EX pipeline boundary for the 16-bit five-stage pipeline. It sits directly upstream of the EX-stage operand forwarder and supplies the EX register specifiers, write-enables and operands that the forwarder and ALU consume. It detects load-use hazards that MEM/WB forwarding cannot cover, inserts a one-cycle bubble, and stalls IF/ID. It also honours branch flushes and whole-pipe memory stalls, and counts inserted bubbles.

---
 rtl/idex_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use bubble insertion,
// branch flush, whole-pipe memory stall and a bubble counter.
module idex_stage #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ID_valid,
  input  logic [2:0]        ID_rX,
  input  logic [2:0]        ID_rY,
  input  logic              ID_uses_X,
  input  logic              ID_uses_Y,
  input  logic [2:0]        ID_rO,
  input  logic              ID_rf_wen,
  input  logic              ID_mem_ren,
  input  logic              ID_mem_wen,
  input  logic [15:0]       ID_opX,
  input  logic [15:0]       ID_opY,
  input  logic [15:0]       ID_imm,
  input  logic [CTRL_W-1:0] ID_ctrl,
  input  logic              flush,
  input  logic              mem_stall,
  input  logic              cnt_clr,
  output logic              EX_valid,
  output logic [2:0]        EX_rX,
  output logic [2:0]        EX_rY,
  output logic [2:0]        EX_rO,
  output logic              EX_rf_wen,
  output logic              EX_mem_ren,
  output logic              EX_mem_wen,
  output logic [15:0]       EX_opX,
  output logic [15:0]       EX_opY,
  output logic [15:0]       EX_imm,
  output logic [CTRL_W-1:0] EX_ctrl,
  output logic              stall_IF_ID,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic [2:0]        rx;
    logic [2:0]        ry;
    logic [2:0]        ro;
    logic              rf_wen;
    logic              mem_ren;
    logic              mem_wen;
    logic [15:0]       opx;
    logic [15:0]       opy;
    logic [15:0]       imm;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  ex_t             ex_q, ex_d, id_ex;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            load_use;
  logic            hit_x, hit_y;

  assign hit_x = ID_uses_X & (ID_rX == ex_q.ro);
  assign hit_y = ID_uses_Y & (ID_rY == ex_q.ro);

  // Only a load sitting in EX cannot be forwarded in time.
  assign load_use = ex_q.valid & ex_q.mem_ren & ex_q.rf_wen
                  & ID_valid & (hit_x | hit_y);

  always_comb begin
    id_ex         = '0;
    id_ex.valid   = ID_valid;
    id_ex.rx      = ID_rX;
    id_ex.ry      = ID_rY;
    id_ex.ro      = ID_rO;
    id_ex.rf_wen  = ID_rf_wen & ID_valid;
    id_ex.mem_ren = ID_mem_ren & ID_valid;
    id_ex.mem_wen = ID_mem_wen & ID_valid;
    id_ex.opx     = ID_opX;
    id_ex.opy     = ID_opY;
    id_ex.imm     = ID_imm;
    id_ex.ctrl    = ID_ctrl;
  end

  always_comb begin
    ex_d = ex_q;
    if (mem_stall) begin
      ex_d = ex_q;
    end else if (flush || load_use) begin
      ex_d = '0;
    end else begin
      ex_d = id_ex;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (!mem_stall && !flush && load_use && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_IF_ID = rst_n & (mem_stall | (load_use & ~flush));

  assign EX_valid   = ex_q.valid;
  assign EX_rX      = ex_q.rx;
  assign EX_rY      = ex_q.ry;
  assign EX_rO      = ex_q.ro;
  assign EX_rf_wen  = ex_q.rf_wen;
  assign EX_mem_ren = ex_q.mem_ren;
  assign EX_mem_wen = ex_q.mem_wen;
  assign EX_opX     = ex_q.opx;
  assign EX_opY     = ex_q.opy;
  assign EX_imm     = ex_q.imm;
  assign EX_ctrl    = ex_q.ctrl;
  assign bubble_cnt = cnt_q;

endmodule
